// File: rtl/lsu_mem_ctrl.sv
// Load/store unit between the execute stage and a byte-addressed,
// little-endian data memory with combinational read and a 4-byte write.
// Sub-word stores do a read-modify-write so neighbouring bytes survive.
// Misaligned, out-of-range and illegal requests are answered with an
// error response and never reach memory.
module lsu_mem_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h01000000,
    parameter int unsigned MEM_BYTES = 1048576
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic        mem_w_enable,
    input  logic [31:0] mem_data_out
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] READ  = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] RESP  = 3'd4;

    // Last valid byte address, one bit wider so the end-of-access sum cannot wrap.
    localparam logic [32:0] LAST_ADDR = {1'b0, BASE_ADDR} + 33'(MEM_BYTES) - 33'd1;

    logic [2:0]  state_reg;
    logic [2:0]  funct3_reg;
    logic [15:0] wdata_reg;
    logic        err_reg;
    logic [31:0] resp_rdata_reg;
    logic [31:0] mem_address_reg;
    logic [31:0] mem_data_in_reg;

    logic [32:0] size_m1;
    logic [32:0] end_addr;
    logic        legal;
    logic        misaligned;
    logic        req_err;
    logic [31:0] load_ext;
    logic [31:0] merged;

    // Classify the incoming request: access size, alignment, range and funct3 legality.
    always_comb begin
        size_m1    = 33'd0;
        legal      = 1'b1;
        misaligned = 1'b0;
        case (req_funct3)
            3'b000: size_m1 = 33'd0;
            3'b001: begin
                size_m1    = 33'd1;
                misaligned = req_addr[0];
            end
            3'b010: begin
                size_m1    = 33'd3;
                misaligned = |req_addr[1:0];
            end
            3'b100: begin
                size_m1 = 33'd0;
                legal   = ~req_we;
            end
            3'b101: begin
                size_m1    = 33'd1;
                misaligned = req_addr[0];
                legal      = ~req_we;
            end
            default: legal = 1'b0;
        endcase
        end_addr = {1'b0, req_addr} + size_m1;
        req_err  = ~legal | misaligned | (req_addr < BASE_ADDR) | (end_addr > LAST_ADDR);
    end

    // Extend the load data; memory always returns the addressed byte in bits [7:0].
    always_comb begin
        case (funct3_reg)
            3'b000:  load_ext = {{24{mem_data_out[7]}}, mem_data_out[7:0]};
            3'b001:  load_ext = {{16{mem_data_out[15]}}, mem_data_out[15:0]};
            3'b100:  load_ext = {24'd0, mem_data_out[7:0]};
            3'b101:  load_ext = {16'd0, mem_data_out[15:0]};
            default: load_ext = mem_data_out;
        endcase
    end

    // Sub-word store merge: overwrite the low byte (SB) or halfword (SH) of the read word.
    always_comb begin
        if (funct3_reg[0]) begin
            merged = {mem_data_out[31:16], wdata_reg[15:0]};
        end else begin
            merged = {mem_data_out[31:8], wdata_reg[7:0]};
        end
    end

    // Request sequencing: accept in IDLE, then walk LOAD / READ->WRITE / WRITE into RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            funct3_reg      <= 3'd0;
            wdata_reg       <= 16'd0;
            err_reg         <= 1'b0;
            resp_rdata_reg  <= 32'd0;
            mem_address_reg <= 32'd0;
            mem_data_in_reg <= 32'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        funct3_reg <= req_funct3;
                        wdata_reg  <= req_wdata[15:0];
                        err_reg    <= req_err;
                        if (req_err) begin
                            state_reg <= RESP;
                        end else begin
                            mem_address_reg <= req_addr;
                            if (!req_we) begin
                                state_reg <= LOAD;
                            end else if (req_funct3 == 3'b010) begin
                                mem_data_in_reg <= req_wdata;
                                state_reg       <= WRITE;
                            end else begin
                                state_reg <= READ;
                            end
                        end
                    end
                end
                LOAD: begin
                    resp_rdata_reg <= load_ext;
                    state_reg      <= RESP;
                end
                READ: begin
                    mem_data_in_reg <= merged;
                    state_reg       <= WRITE;
                end
                WRITE: state_reg <= RESP;
                RESP: begin
                    err_reg   <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign req_ready    = (state_reg == IDLE) & ~reset;
    assign resp_valid   = (state_reg == RESP);
    assign resp_err     = (state_reg == RESP) & err_reg;
    assign resp_rdata   = resp_rdata_reg;
    assign mem_address  = mem_address_reg;
    assign mem_data_in  = mem_data_in_reg;
    assign mem_w_enable = (state_reg == WRITE);

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: a 1 MiB byte memory attached to the unit, directed
// scenarios followed by random requests checked against a byte-level model.
module tb_lsu_mem_ctrl;

    localparam logic [31:0] BASE = 32'h01000000;
    localparam int unsigned MEMB = 1048576;
    localparam int unsigned MASK = MEMB - 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic        mem_w_enable;
    logic [31:0] mem_data_out;

    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] exp_rdata = 32'd0;

    // Reference: sparse byte map of what memory should contain.
    byte unsigned ref_mem [int unsigned];

    logic [7:0] mem [0:MEMB-1];

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.BASE_ADDR(BASE), .MEM_BYTES(MEMB)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_w_enable(mem_w_enable), .mem_data_out(mem_data_out)
    );

    function automatic int unsigned mi(input logic [31:0] a, input int unsigned k);
        return (a - BASE + k) & MASK;
    endfunction

    always_comb begin
        mem_data_out = {mem[mi(mem_address, 3)], mem[mi(mem_address, 2)],
                        mem[mi(mem_address, 1)], mem[mi(mem_address, 0)]};
    end

    always @(posedge clk) begin
        if (mem_w_enable) begin
            for (int k = 0; k < 4; k++) mem[mi(mem_address, k)] <= mem_data_in[8*k +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rb(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'd0;
    endfunction

    // Run one request end to end and compare against the model.
    task automatic txn(input bit we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int size;
        bit legal;
        bit e;
        int lat;
        int cyc;
        int wen;
        longint last;
        logic [31:0] v;
        legal = 1'b1;
        size = 1;
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    legal = 1'b0;
        endcase
        if (we && f3 >= 3'd4) legal = 1'b0;
        last = longint'(a) + size - 1;
        e = !legal || (a % size != 0) || (a < BASE) || (last > longint'(BASE) + MEMB - 1);
        if (e) lat = 1;
        else if (!we) lat = 2;
        else if (size == 4) lat = 2;
        else lat = 3;
        if (!e && !we) begin
            v = {rb(a + 3), rb(a + 2), rb(a + 1), rb(a)};
            case (f3)
                3'd0: v = 32'($signed(v[7:0]));
                3'd1: v = 32'($signed(v[15:0]));
                3'd4: v = {24'd0, v[7:0]};
                3'd5: v = {16'd0, v[15:0]};
                default: ;
            endcase
            exp_rdata = v;
        end
        @(negedge clk);
        chk("ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        cyc = 0;
        wen = 0;
        for (int c = 1; c <= 8 && cyc == 0; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (mem_w_enable) wen++;
            if (resp_valid) cyc = c;
        end
        chk("latency", 32'(cyc), 32'(lat));
        chk("resp_err", 32'(resp_err), 32'(e));
        chk("wen_count", 32'(wen), (!e && we) ? 32'd1 : 32'd0);
        chk("resp_rdata", resp_rdata, exp_rdata);
        if (!e && we) begin
            for (int i = 0; i < size; i++) ref_mem[a + i] = wd[8*i +: 8];
        end
        $display("txn we=%0d f3=%0d addr=%h wdata=%h err=%0d rdata=%h lat=%0d",
                 we, f3, a, wd, resp_err, resp_rdata, cyc);
    endtask

    initial begin
        int r1;
        int r2;
        int wen;
        logic [31:0] a;
        logic [2:0] f3;
        logic [2:0] legal_f3 [5];
        legal_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        for (int i = 0; i < int'(MEMB); i++) mem[i] = 8'd0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("ready_in_reset", 32'(req_ready), 32'd0);
        reset = 1'b0;
        #1;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_mem_address", mem_address, 32'd0);
        chk("rst_mem_data_in", mem_data_in, 32'd0);
        chk("rst_wen", 32'(mem_w_enable), 32'd0);

        // Sign/zero-extended byte loads
        txn(1'b1, 3'd2, 32'h01000000, 32'h87654321);
        txn(1'b0, 3'd0, 32'h01000003, 32'd0);
        txn(1'b0, 3'd4, 32'h01000003, 32'd0);
        // Byte store keeps neighbours
        txn(1'b1, 3'd0, 32'h01000001, 32'h123456AA);
        txn(1'b0, 3'd2, 32'h01000000, 32'd0);
        // Halfword loads and store
        txn(1'b1, 3'd2, 32'h01000004, 32'hDEADBEEF);
        txn(1'b0, 3'd1, 32'h01000006, 32'd0);
        txn(1'b0, 3'd5, 32'h01000004, 32'd0);
        txn(1'b1, 3'd1, 32'h01000004, 32'h00001111);
        txn(1'b0, 3'd2, 32'h01000004, 32'd0);
        // Error cases and the top boundary
        txn(1'b0, 3'd2, 32'h01000002, 32'd0);
        txn(1'b1, 3'd2, 32'h00FFFFFC, 32'hCAFEF00D);
        txn(1'b1, 3'd2, 32'h010FFFFC, 32'hA5A55A5A);
        txn(1'b0, 3'd2, 32'h010FFFFC, 32'd0);
        txn(1'b1, 3'd0, 32'h01100000, 32'h000000FF);
        txn(1'b0, 3'd3, 32'h01000000, 32'd0);
        txn(1'b1, 3'd4, 32'h01000000, 32'd0);

        // Back-to-back loads with req_valid held high
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h01000004;
        exp_rdata = {rb(32'h01000007), rb(32'h01000006), rb(32'h01000005), rb(32'h01000004)};
        r1 = -1;
        r2 = -1;
        for (int c = 0; c < 12 && r2 < 0; c++) begin
            if (c == 0 || c == 3) chk("b2b_ready_hi", 32'(req_ready), 32'd1);
            if (c == 1 || c == 2 || c == 4 || c == 5) chk("b2b_ready_lo", 32'(req_ready), 32'd0);
            if (resp_valid) begin
                chk("b2b_rdata", resp_rdata, exp_rdata);
                if (r1 < 0) r1 = c;
                else begin
                    r2 = c;
                    req_valid = 1'b0;
                end
            end
            if (r2 < 0) @(negedge clk);
        end
        chk("b2b_first_resp", 32'(r1), 32'd2);
        chk("b2b_spacing", 32'(r2 - r1), 32'd3);
        $display("txn b2b loads first_resp=%0d second_resp=%0d", r1, r2);

        // Reset while an SB is in READ
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h01000008; req_wdata = 32'h000000EE;
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b1;
        wen = mem_w_enable ? 1 : 0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_mid_ready", 32'(req_ready), 32'd1);
        chk("rst_mid_resp", 32'(resp_valid), 32'd0);
        chk("rst_mid_rdata", resp_rdata, 32'd0);
        exp_rdata = 32'd0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (mem_w_enable) wen++;
            chk("rst_mid_no_resp", 32'(resp_valid), 32'd0);
        end
        chk("rst_mid_wen", 32'(wen), 32'd0);
        $display("txn reset during READ of SB at 01000008");
        txn(1'b0, 3'd2, 32'h01000008, 32'd0);

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(7))
                0, 1, 2, 3, 4: a = BASE + $urandom_range(31);
                5:             a = BASE + MEMB - 8 + $urandom_range(7);
                6:             a = BASE - 1 - $urandom_range(3);
                default:       a = $urandom;
            endcase
            if ($urandom_range(3) != 0) f3 = legal_f3[$urandom_range(4)];
            else f3 = 3'($urandom_range(7));
            txn(1'($urandom_range(1)), f3, a, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
